// File: rtl/uart_pkg.sv
// Shared types and constants for the UART configuration sequencer.
// Reset-default line settings and nominal baud periods live here.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2,
    ST_QUIET = 2'd3
  } cfg_state_e;

  typedef struct packed {
    logic [2:0] umode;
    logic [1:0] smode;
    logic [4:0] bmode;
  } uart_cfg_t;

  localparam logic [2:0] UMODE_DEF = 3'b110;
  localparam logic [1:0] SMODE_DEF = 2'b00;
  localparam logic [4:0] BMODE_DEF = 5'b01000;
  localparam uart_cfg_t  CFG_DEF   = '{umode: UMODE_DEF, smode: SMODE_DEF, bmode: BMODE_DEF};

  // Baud periods in sclk cycles
  localparam int B4800  = 2604;
  localparam int B9600  = 1302;
  localparam int B14_4K = 868;
  localparam int B19_2K = 651;

endpackage

// File: rtl/uart_line_quiet.sv
// Counts consecutive high cycles on the RX line; flags when the line
// has been idle long enough to release the cores.
module uart_line_quiet #(
  parameter int QUIET_CYC = 104160,
  parameter int QW        = 17
) (
  input  logic sclk,
  input  logic sclr_n,
  input  logic clr,
  input  logic rx,
  output logic quiet_done
);

  localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYC - 1);

  logic [QW-1:0] cnt;

  always_ff @(posedge sclk or negedge sclr_n) begin
    if (!sclr_n) begin
      cnt <= '0;
    end else if (clr || !rx) begin
      cnt <= '0;
    end else if (cnt != QUIET_LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Done on the cycle that would be the QUIET_CYC-th consecutive high sample
  assign quiet_done = rx && (cnt == QUIET_LAST);

endmodule

// File: rtl/uart_cfg_ctrl.sv
// Configuration sequencer for the UART cores: applies host settings behind
// a drain / clear / quiet-line sequence and counts RX framing errors.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_RUN   | cores live, host writes accepted, RX errors counted
// ST_DRAIN | waiting for TX frame to finish (bounded by DRAIN_MAX)
// ST_HOLD  | cores held in clear for CLR_CYC cycles, new modes applied
// ST_QUIET | cores still in clear, waiting for QUIET_CYC idle RX cycles
module uart_cfg_ctrl
  import uart_pkg::*;
#(
  parameter int CLR_CYC   = 4,
  parameter int QUIET_CYC = 104160,
  parameter int QW        = 17,
  parameter int DRAIN_MAX = 131071,
  parameter int ERR_W     = 8
) (
  input  logic             sclk,
  input  logic             sclr_n,
  input  logic             cfg_wr,
  input  logic [2:0]       cfg_umode,
  input  logic [1:0]       cfg_smode,
  input  logic [4:0]       cfg_bmode,
  output logic             cfg_busy,
  output logic             cfg_ack,
  input  logic             rx,
  input  logic             tx_busy,
  input  logic             rx_err,
  input  logic             err_clr,
  output logic [2:0]       umode,
  output logic [1:0]       smode,
  output logic [4:0]       bmode,
  output logic             core_sclr,
  output logic             link_up,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int CW = $clog2(((DRAIN_MAX > CLR_CYC) ? DRAIN_MAX : CLR_CYC) + 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_MAX - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CLR_CYC - 1);

  cfg_state_e state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  uart_cfg_t shadow, shadow_d;
  uart_cfg_t live, live_d;
  logic sclr_d, busy_d, ack_d, link_d;
  logic quiet_done;
  logic quiet_clr;
  logic rx_err_q;

  assign quiet_clr = (state != ST_QUIET);

  uart_line_quiet #(
    .QUIET_CYC(QUIET_CYC),
    .QW       (QW)
  ) u_line_quiet (
    .sclk      (sclk),
    .sclr_n    (sclr_n),
    .clr       (quiet_clr),
    .rx        (rx),
    .quiet_done(quiet_done)
  );

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    shadow_d = shadow;
    live_d   = live;
    sclr_d   = core_sclr;
    busy_d   = cfg_busy;
    ack_d    = 1'b0;
    link_d   = link_up;
    case (state)
      ST_RUN: begin
        if (cfg_wr) begin
          shadow_d = '{umode: cfg_umode, smode: cfg_smode, bmode: cfg_bmode};
          state_d  = ST_DRAIN;
          cnt_d    = '0;
          busy_d   = 1'b1;
          link_d   = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (!tx_busy || (cnt == DRAIN_LAST)) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          sclr_d  = 1'b1;
          live_d  = shadow;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_d = ST_QUIET;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_QUIET: begin
        if (quiet_done) begin
          state_d = ST_RUN;
          sclr_d  = 1'b0;
          busy_d  = 1'b0;
          ack_d   = 1'b1;
          link_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
        sclr_d  = 1'b1;
        busy_d  = 1'b1;
        link_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sclk or negedge sclr_n) begin
    if (!sclr_n) begin
      state     <= ST_HOLD;
      cnt       <= '0;
      shadow    <= CFG_DEF;
      live      <= CFG_DEF;
      core_sclr <= 1'b1;
      cfg_busy  <= 1'b1;
      cfg_ack   <= 1'b0;
      link_up   <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      shadow    <= shadow_d;
      live      <= live_d;
      core_sclr <= sclr_d;
      cfg_busy  <= busy_d;
      cfg_ack   <= ack_d;
      link_up   <= link_d;
    end
  end

  // Clear has priority over a same-cycle increment; edges outside RUN are dropped
  always_ff @(posedge sclk or negedge sclr_n) begin
    if (!sclr_n) begin
      err_cnt  <= '0;
      rx_err_q <= 1'b0;
    end else begin
      rx_err_q <= rx_err;
      if (err_clr) begin
        err_cnt <= '0;
      end else if ((state == ST_RUN) && rx_err && !rx_err_q && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

  assign umode = live.umode;
  assign smode = live.smode;
  assign bmode = live.bmode;

endmodule

// File: tb/tb_uart_cfg_ctrl.sv
// Scoreboard bench for uart_cfg_ctrl: the driver predicts ack/clear timing
// and applied settings from the sequencing rules; a monitor checks them.
module tb_uart_cfg_ctrl;

  localparam int CLR_CYC   = 4;
  localparam int QUIET_CYC = 20;
  localparam int DRAIN_MAX = 50;
  localparam int QW        = 17;
  localparam int ERR_W     = 8;
  localparam int NONE      = -100;
  localparam logic [9:0] CFG_DEF = 10'b110_00_01000;

  logic       sclk = 1'b0;
  logic       sclr_n = 1'b1;
  logic       cfg_wr = 1'b0;
  logic [2:0] cfg_umode = '0;
  logic [1:0] cfg_smode = '0;
  logic [4:0] cfg_bmode = '0;
  logic       rx = 1'b1;
  logic       tx_busy = 1'b0;
  logic       rx_err = 1'b0;
  logic       err_clr = 1'b0;
  logic       cfg_busy, cfg_ack, core_sclr, link_up;
  logic [2:0] umode;
  logic [1:0] smode;
  logic [4:0] bmode;
  logic [ERR_W-1:0] err_cnt;

  uart_cfg_ctrl #(
    .CLR_CYC  (CLR_CYC),
    .QUIET_CYC(QUIET_CYC),
    .QW       (QW),
    .DRAIN_MAX(DRAIN_MAX),
    .ERR_W    (ERR_W)
  ) dut (
    .sclk     (sclk),
    .sclr_n   (sclr_n),
    .cfg_wr   (cfg_wr),
    .cfg_umode(cfg_umode),
    .cfg_smode(cfg_smode),
    .cfg_bmode(cfg_bmode),
    .cfg_busy (cfg_busy),
    .cfg_ack  (cfg_ack),
    .rx       (rx),
    .tx_busy  (tx_busy),
    .rx_err   (rx_err),
    .err_clr  (err_clr),
    .umode    (umode),
    .smode    (smode),
    .bmode    (bmode),
    .core_sclr(core_sclr),
    .link_up  (link_up),
    .err_cnt  (err_cnt)
  );

  always #5 sclk = ~sclk;

  int cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  typedef struct {
    int         ack_cyc;
    int         sclr_cyc;
    logic [9:0] cfg;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  int         err_model = 0;
  logic [9:0] live_cfg = CFG_DEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: sampled on the falling edge
  logic prev_sclr = 1'b1;
  always @(negedge sclk) begin
    logic [9:0] cur;
    exp_t e;
    cur = {umode, smode, bmode};
    if (!sclr_n) begin
      prev_sclr = 1'b1;
    end else begin
      if (core_sclr && !prev_sclr) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sclr_rise: unexpected clear at cycle %0d", cyc);
        end else begin
          check("sclr_rise_cyc", cyc, sb_q[0].sclr_cyc);
          check("cfg_at_hold", cur, sb_q[0].cfg);
          live_cfg = sb_q[0].cfg;
        end
      end
      if (!core_sclr && prev_sclr) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sclr_fall: unexpected release at cycle %0d", cyc);
        end else begin
          check("sclr_fall_cyc", cyc, sb_q[0].ack_cyc);
        end
      end
      if (cfg_ack) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ack: unexpected cfg_ack at cycle %0d", cyc);
        end else begin
          e = sb_q.pop_front();
          check("ack_cyc", cyc, e.ack_cyc);
          check("cfg_at_ack", cur, e.cfg);
          check("sclr_at_ack", core_sclr, 0);
          check("busy_at_ack", cfg_busy, 0);
          check("link_at_ack", link_up, 1);
          live_cfg = e.cfg;
        end
      end
      if (!core_sclr) check("cfg_stable_unclear", cur, live_cfg);
      prev_sclr = core_sclr;
    end
  end

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic do_reset();
    exp_t e;
    sclr_n = 1'b0; cfg_wr = 1'b0; tx_busy = 1'b0; rx = 1'b1; rx_err = 1'b0; err_clr = 1'b0;
    #2;
    check("rst_umode", umode, 3'b110);
    check("rst_smode", smode, 2'b00);
    check("rst_bmode", bmode, 5'b01000);
    check("rst_sclr", core_sclr, 1);
    check("rst_busy", cfg_busy, 1);
    check("rst_ack", cfg_ack, 0);
    check("rst_link", link_up, 0);
    check("rst_err", err_cnt, 0);
    sb_q.delete();
    live_cfg  = CFG_DEF;
    err_model = 0;
    step();
    step();
    sclr_n = 1'b1;
    e = '{cyc + CLR_CYC + QUIET_CYC, NONE, CFG_DEF};
    sb_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < 300) begin
      step();
      n++;
    end
    if (sb_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL wait_idle: %0d expected acks never arrived", sb_q.size());
      sb_q.delete();
    end
  endtask

  // One host write; busy_len = cycles TX_BUSY is high starting with the write
  // cycle, glitch_off = RX-low cycle relative to the first QUIET cycle,
  // wr2_off = extra write offset (-1: the last QUIET cycle).
  task automatic do_cfg(input logic [9:0] ncfg, input int busy_len, input int glitch_off,
                        input int wr2_off, input logic [9:0] cfg2, input bit err_in_quiet);
    int c, k, q, g, j, w2;
    exp_t e;
    c = cyc;
    k = (busy_len < 1) ? 1 : busy_len;
    if (k > DRAIN_MAX) k = DRAIN_MAX;
    q = c + k + 1 + CLR_CYC;
    g = q + glitch_off;
    if (glitch_off >= 0 && glitch_off < QUIET_CYC) j = g + QUIET_CYC;
    else j = q + QUIET_CYC - 1;
    w2 = (wr2_off == -1) ? j : ((wr2_off > 0) ? c + wr2_off : NONE);
    e = '{j + 1, c + k + 1, ncfg};
    sb_q.push_back(e);
    for (int t = c; t <= j + 3; t++) begin
      cfg_wr  = (t == c) || (t == w2);
      {cfg_umode, cfg_smode, cfg_bmode} = (t == c) ? ncfg : cfg2;
      tx_busy = (t - c) < busy_len;
      rx      = !(glitch_off != NONE && t == g);
      rx_err  = err_in_quiet && (t == q + 5);
      step();
      if (t == c) begin
        check("busy_after_wr", cfg_busy, 1);
        check("link_after_wr", link_up, 0);
      end
    end
    cfg_wr = 1'b0; tx_busy = 1'b0; rx = 1'b1; rx_err = 1'b0;
    wait_idle();
  endtask

  task automatic err_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      rx_err = 1'b1;
      step();
      rx_err = 1'b0;
      step();
    end
    err_model = (err_model + n > 255) ? 255 : err_model + n;
    check("err_cnt", err_cnt, err_model);
  endtask

  task automatic err_clear_with_edge();
    rx_err  = 1'b1;
    err_clr = 1'b1;
    step();
    rx_err  = 1'b0;
    err_clr = 1'b0;
    err_model = 0;
    check("err_clr_wins", err_cnt, 0);
    step();
  endtask

  initial begin
    #1;
    do_reset();
    wait_idle();

    do_cfg(10'b011_01_00100, 0, NONE, 0, 10'h0, 1'b0);
    do_cfg(10'($urandom), 10, NONE, 0, 10'h0, 1'b0);
    do_cfg(10'($urandom), 70, NONE, 0, 10'h0, 1'b0);
    do_cfg(10'($urandom), 0, 14, 0, 10'h0, 1'b0);
    do_cfg(10'b001_10_10101, 0, NONE, 3, 10'b111_11_11111, 1'b0);
    do_cfg(10'b010_11_00011, 5, NONE, -1, 10'b101_01_11100, 1'b0);

    err_pulses(300);
    err_clear_with_edge();
    err_pulses(7);
    do_cfg(10'($urandom), 0, NONE, 0, 10'h0, 1'b1);
    check("err_after_quiet_edge", err_cnt, err_model);

    for (int i = 0; i < 12; i++) begin
      int bl, gl, w2;
      bl = $urandom_range(0, 60);
      gl = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 22)) - 3 : NONE;
      w2 = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, bl + 5)) : 0;
      do_cfg(10'($urandom), bl, gl, w2, 10'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) err_clear_with_edge();
      err_pulses($urandom_range(0, 30));
    end

    // Reset in the middle of HOLD abandons the pending configuration
    begin
      exp_t e;
      e = '{cyc + 26, cyc + 2, 10'b000_11_11111};
      sb_q.push_back(e);
      cfg_wr = 1'b1;
      {cfg_umode, cfg_smode, cfg_bmode} = 10'b000_11_11111;
      step();
      cfg_wr = 1'b0;
      repeat (4) step();
      do_reset();
      wait_idle();
      check("umode_after_midreset", umode, 3'b110);
      check("bmode_after_midreset", bmode, 5'b01000);
    end

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
